// File: rtl/data_bus_bridge_if.sv
// Core data-memory port plus data-RAM port, bundled for the data_bus_bridge.
// slave = bridge view; master = core/RAM side driving the bridge.
interface data_bus_bridge_if;
    logic [31:0] data_raddr;
    logic        data_re;
    logic [31:0] data_rdata;
    logic [31:0] data_waddr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_we;
    logic [31:0] ram_raddr;
    logic        ram_re;
    logic [31:0] ram_rdata;
    logic [31:0] ram_waddr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_wstrb;
    logic        ram_we;

    modport slave (
        input  data_raddr, data_re, data_waddr, data_wdata, data_wstrb, data_we, ram_rdata,
        output data_rdata, ram_raddr, ram_re, ram_waddr, ram_wdata, ram_wstrb, ram_we
    );

    modport master (
        output data_raddr, data_re, data_waddr, data_wdata, data_wstrb, data_we, ram_rdata,
        input  data_rdata, ram_raddr, ram_re, ram_waddr, ram_wdata, ram_wstrb, ram_we
    );
endinterface

// File: rtl/data_bus_bridge.sv
// Core data-port bridge: decodes RAM vs. peripheral window (LED, SW, TIMER, TIMECMP, STATUS).
// Optional macro BRIDGE_PRESCALE_EN: TIMER advances once every PRESCALE cycles.
module data_bus_bridge #(
    parameter logic [31:0] PERIPH_BASE = 32'h8000_F000,
    parameter int          LED_W       = 16,
    parameter int          SW_W        = 16,
    parameter int          PRESCALE    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    data_bus_bridge_if.slave   bus,
    input  logic [SW_W-1:0]    sw_in,
    output logic [LED_W-1:0]   led_out,
    output logic               timer_irq
);

    localparam logic [19:0] PERIPH_PAGE = PERIPH_BASE[31:12];
    localparam logic [9:0]  IDX_LED     = 10'd0;
    localparam logic [9:0]  IDX_SW      = 10'd1;
    localparam logic [9:0]  IDX_TIMER   = 10'd2;
    localparam logic [9:0]  IDX_TIMECMP = 10'd3;
    localparam logic [9:0]  IDX_STATUS  = 10'd4;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return r;
    endfunction

    logic        rd_periph;
    logic        wr_periph;
    logic [9:0]  rd_idx;
    logic [9:0]  wr_idx;
    logic        wr_any;
    logic        led_we;
    logic        timer_we;
    logic        timecmp_we;

    logic [LED_W-1:0] led_q;
    logic [SW_W-1:0]  sw_meta;
    logic [SW_W-1:0]  sw_sync;
    logic [31:0]      timer_q;
    logic [31:0]      timecmp_q;
    logic [31:0]      led_ext;
    logic [31:0]      sw_ext;
    logic [31:0]      led_merged;
    logic [31:0]      periph_rword;
    logic [31:0]      rd_word;
    logic             rd_sel;
    logic             tick;

    assign rd_periph = (bus.data_raddr[31:12] == PERIPH_PAGE);
    assign wr_periph = (bus.data_waddr[31:12] == PERIPH_PAGE);
    assign rd_idx    = bus.data_raddr[11:2];
    assign wr_idx    = bus.data_waddr[11:2];

    // RAM side is pure pass-through; only the enables are gated by the decode
    assign bus.ram_raddr = bus.data_raddr;
    assign bus.ram_waddr = bus.data_waddr;
    assign bus.ram_wdata = bus.data_wdata;
    assign bus.ram_wstrb = bus.data_wstrb;
    assign bus.ram_re    = bus.data_re & ~rd_periph;
    assign bus.ram_we    = bus.data_we & ~wr_periph;

    assign wr_any     = bus.data_we & wr_periph & (|bus.data_wstrb);
    assign led_we     = wr_any & (wr_idx == IDX_LED);
    assign timer_we   = wr_any & (wr_idx == IDX_TIMER);
    assign timecmp_we = wr_any & (wr_idx == IDX_TIMECMP);

    always_comb begin
        led_ext = '0;
        led_ext[LED_W-1:0] = led_q;
        sw_ext = '0;
        sw_ext[SW_W-1:0] = sw_sync;
    end

    assign led_merged = merge_bytes(led_ext, bus.data_wdata, bus.data_wstrb);

    always_comb begin
        periph_rword = '0;
        case (rd_idx)
            IDX_LED:     periph_rword = led_ext;
            IDX_SW:      periph_rword = sw_ext;
            IDX_TIMER:   periph_rword = timer_q;
            IDX_TIMECMP: periph_rword = timecmp_q;
            IDX_STATUS:  periph_rword = {31'b0, timer_irq};
            default:     periph_rword = '0;
        endcase
    end

`ifdef BRIDGE_PRESCALE_EN
    localparam int PS_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    logic [PS_W-1:0] ps_cnt;

    assign tick = (ps_cnt == PS_W'(PRESCALE - 1));

    // A TIMER write restarts the prescale period so the written value holds a full period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ps_cnt <= '0;
        else if (timer_we || tick)
            ps_cnt <= '0;
        else
            ps_cnt <= ps_cnt + 1'b1;
    end
`else
    logic [31:0] unused_prescale;
    assign unused_prescale = PRESCALE;
    assign tick = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q     <= '0;
            timer_q   <= '0;
            timecmp_q <= 32'hFFFF_FFFF;
            timer_irq <= 1'b0;
            sw_meta   <= '0;
            sw_sync   <= '0;
        end else begin
            sw_meta   <= sw_in;
            sw_sync   <= sw_meta;
            timer_irq <= (timer_q >= timecmp_q);
            if (led_we)
                led_q <= led_merged[LED_W-1:0];
            if (timecmp_we)
                timecmp_q <= merge_bytes(timecmp_q, bus.data_wdata, bus.data_wstrb);
            if (timer_we)
                timer_q <= merge_bytes(timer_q, bus.data_wdata, bus.data_wstrb);
            else if (tick)
                timer_q <= timer_q + 32'd1;
        end
    end

    // Read word is captured before this cycle's write lands, so same-cycle RAW returns the old value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sel  <= 1'b0;
            rd_word <= '0;
        end else if (bus.data_re) begin
            rd_sel  <= rd_periph;
            rd_word <= periph_rword;
        end
    end

    assign bus.data_rdata = rd_sel ? rd_word : bus.ram_rdata;
    assign led_out        = led_q;

endmodule

// File: tb/tb_data_bus_bridge.sv
// Directed self-checking bench for data_bus_bridge (default or BRIDGE_PRESCALE_EN build).
module tb_data_bus_bridge;

`ifdef BRIDGE_PRESCALE_EN
    localparam int P = 4;
`else
    localparam int P = 1;
`endif

    localparam logic [31:0] A_LED     = 32'h8000_F000;
    localparam logic [31:0] A_SW      = 32'h8000_F004;
    localparam logic [31:0] A_TIMER   = 32'h8000_F008;
    localparam logic [31:0] A_TIMECMP = 32'h8000_F00C;
    localparam logic [31:0] A_STATUS  = 32'h8000_F010;
    localparam logic [31:0] A_UNMAP   = 32'h8000_F020;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sw_in = '0;
    logic [15:0] led_out;
    logic        timer_irq;
    int          n_cmp = 0;
    int          n_err = 0;

    data_bus_bridge_if bus();

    data_bus_bridge #(
        .PERIPH_BASE(32'h8000_F000),
        .LED_W(16),
        .SW_W(16),
        .PRESCALE(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .sw_in(sw_in),
        .led_out(led_out),
        .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        @(negedge clk);
        bus.data_waddr = addr;
        bus.data_wdata = data;
        bus.data_wstrb = strb;
        bus.data_we    = 1'b1;
        @(posedge clk);
        #1;
        bus.data_we    = 1'b0;
        bus.data_wstrb = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] ram_resp, output logic [31:0] rdata);
        @(negedge clk);
        bus.data_raddr = addr;
        bus.data_re    = 1'b1;
        @(posedge clk);
        #1;
        bus.data_re    = 1'b0;
        bus.ram_rdata  = ram_resp;
        #1;
        rdata = bus.data_rdata;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(A_TIMECMP, 32'h0, rd);
        n_cmp++;
        if (rd !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL reset_timecmp: got %h expected %h", rd, 32'hFFFF_FFFF);
        end
        n_cmp++;
        if (led_out !== 16'h0) begin
            n_err++;
            $display("FAIL reset_led: got %h expected %h", led_out, 16'h0);
        end
        n_cmp++;
        if (timer_irq !== 1'b0) begin
            n_err++;
            $display("FAIL reset_irq: got %b expected %b", timer_irq, 1'b0);
        end
    endtask

    task automatic test_ram_path();
        @(negedge clk);
        bus.data_raddr = 32'h0000_0100;
        bus.data_re    = 1'b1;
        #1;
        n_cmp++;
        if (bus.ram_re !== 1'b1) begin
            n_err++;
            $display("FAIL ram_re: got %b expected %b", bus.ram_re, 1'b1);
        end
        n_cmp++;
        if (bus.ram_raddr !== 32'h0000_0100) begin
            n_err++;
            $display("FAIL ram_raddr: got %h expected %h", bus.ram_raddr, 32'h100);
        end
        @(posedge clk);
        #1;
        bus.data_re   = 1'b0;
        bus.ram_rdata = 32'hDEAD_BEEF;
        #1;
        n_cmp++;
        if (bus.data_rdata !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL ram_rdata: got %h expected %h", bus.data_rdata, 32'hDEAD_BEEF);
        end
        @(negedge clk);
        bus.data_waddr = 32'h0000_0100;
        bus.data_wdata = 32'h1234_5678;
        bus.data_wstrb = 4'hF;
        bus.data_we    = 1'b1;
        #1;
        n_cmp++;
        if (bus.ram_we !== 1'b1 || bus.ram_wdata !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL ram_we_ram: got we=%b data=%h expected we=1 data=12345678", bus.ram_we, bus.ram_wdata);
        end
        bus.data_waddr = A_LED;
        bus.data_wstrb = 4'h0;
        #1;
        n_cmp++;
        if (bus.ram_we !== 1'b0) begin
            n_err++;
            $display("FAIL ram_we_periph: got %b expected %b", bus.ram_we, 1'b0);
        end
        @(posedge clk);
        #1;
        bus.data_we = 1'b0;
    endtask

    task automatic test_led_strobes();
        logic [31:0] rd;
        bus_write(A_LED, 32'h0000_ABCD, 4'b0011);
        n_cmp++;
        if (led_out !== 16'hABCD) begin
            n_err++;
            $display("FAIL led_full: got %h expected %h", led_out, 16'hABCD);
        end
        bus_write(A_LED, 32'h0000_1200, 4'b0010);
        n_cmp++;
        if (led_out !== 16'h12CD) begin
            n_err++;
            $display("FAIL led_byte1: got %h expected %h", led_out, 16'h12CD);
        end
        bus_read(A_LED, 32'hFFFF_FFFF, rd);
        n_cmp++;
        if (rd !== 32'h0000_12CD) begin
            n_err++;
            $display("FAIL led_readback: got %h expected %h", rd, 32'h12CD);
        end
    endtask

    task automatic test_timer_wrap();
        logic [31:0] rd;
        logic [31:0] exp;
        bus_write(A_TIMER, 32'hFFFF_FFFE, 4'hF);
        for (int k = 0; k < 3; k++) begin
            bus_read(A_TIMER, 32'h0, rd);
            exp = 32'hFFFF_FFFE + 32'(k / P);
            n_cmp++;
            if (rd !== exp) begin
                n_err++;
                $display("FAIL timer_wrap_%0d: got %h expected %h", k, rd, exp);
            end
        end
    endtask

    task automatic test_timer_irq();
        logic [31:0] rd;
        bus_write(A_TIMECMP, 32'd5, 4'hF);
        bus_write(A_TIMER, 32'd0, 4'hF);
        repeat (5 * P) @(posedge clk);
        #1;
        n_cmp++;
        if (timer_irq !== 1'b0) begin
            n_err++;
            $display("FAIL irq_before: got %b expected %b", timer_irq, 1'b0);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (timer_irq !== 1'b1) begin
            n_err++;
            $display("FAIL irq_rise: got %b expected %b", timer_irq, 1'b1);
        end
        bus_read(A_STATUS, 32'h0, rd);
        n_cmp++;
        if (rd !== 32'h1) begin
            n_err++;
            $display("FAIL status_irq: got %h expected %h", rd, 32'h1);
        end
        bus_write(A_TIMECMP, 32'hFFFF_FFFF, 4'hF);
        n_cmp++;
        if (timer_irq !== 1'b1) begin
            n_err++;
            $display("FAIL irq_hold: got %b expected %b", timer_irq, 1'b1);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (timer_irq !== 1'b0) begin
            n_err++;
            $display("FAIL irq_clear: got %b expected %b", timer_irq, 1'b0);
        end
    endtask

    task automatic test_switch_sync();
        logic [31:0] rd;
        logic [31:0] exp_seq [3];
        exp_seq[0] = 32'h0;
        exp_seq[1] = 32'h0;
        exp_seq[2] = 32'h0000_00A5;
        sw_in = 16'h00A5;
        for (int k = 0; k < 3; k++) begin
            bus_read(A_SW, 32'hFFFF_FFFF, rd);
            n_cmp++;
            if (rd !== exp_seq[k]) begin
                n_err++;
                $display("FAIL sw_sync_%0d: got %h expected %h", k, rd, exp_seq[k]);
            end
        end
    endtask

    task automatic test_same_cycle();
        @(negedge clk);
        bus.data_raddr = A_LED;
        bus.data_re    = 1'b1;
        bus.data_waddr = A_LED;
        bus.data_wdata = 32'h0000_5555;
        bus.data_wstrb = 4'b0011;
        bus.data_we    = 1'b1;
        @(posedge clk);
        #1;
        bus.data_re    = 1'b0;
        bus.data_we    = 1'b0;
        bus.data_wstrb = 4'h0;
        bus.ram_rdata  = 32'hFFFF_FFFF;
        #1;
        n_cmp++;
        if (bus.data_rdata !== 32'h0000_12CD) begin
            n_err++;
            $display("FAIL raw_old_value: got %h expected %h", bus.data_rdata, 32'h12CD);
        end
        n_cmp++;
        if (led_out !== 16'h5555) begin
            n_err++;
            $display("FAIL raw_led_written: got %h expected %h", led_out, 16'h5555);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] rd;
        bus_write(A_UNMAP, 32'hFFFF_FFFF, 4'hF);
        bus_read(A_UNMAP, 32'hFFFF_FFFF, rd);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_err++;
            $display("FAIL unmapped_read: got %h expected %h", rd, 32'h0);
        end
        n_cmp++;
        if (led_out !== 16'h5555) begin
            n_err++;
            $display("FAIL unmapped_no_side_effect: got %h expected %h", led_out, 16'h5555);
        end
    endtask

    task automatic test_prescale();
        logic [31:0] rd;
        logic [31:0] exp;
        exp = 32'(12 / P);
        bus_write(A_TIMER, 32'd0, 4'hF);
        repeat (12) @(posedge clk);
        bus_read(A_TIMER, 32'h0, rd);
        n_cmp++;
        if (rd !== exp) begin
            n_err++;
            $display("FAIL timer_idle12: got %0d expected %0d", rd, exp);
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] rd;
        bus_write(A_TIMECMP, 32'h0, 4'hF);
        @(posedge clk);
        #1;
        n_cmp++;
        if (timer_irq !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_irq: got %b expected %b", timer_irq, 1'b1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (led_out !== 16'h0 || timer_irq !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: got led=%h irq=%b expected led=0000 irq=0", led_out, timer_irq);
        end
        bus.data_raddr = 32'h0000_0200;
        bus.data_re    = 1'b1;
        #1;
        n_cmp++;
        if (bus.ram_re !== 1'b1 || bus.ram_raddr !== 32'h0000_0200) begin
            n_err++;
            $display("FAIL reset_passthrough: got re=%b addr=%h expected re=1 addr=00000200", bus.ram_re, bus.ram_raddr);
        end
        bus.data_re = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(A_TIMECMP, 32'h0, rd);
        n_cmp++;
        if (rd !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL post_reset_timecmp: got %h expected %h", rd, 32'hFFFF_FFFF);
        end
    endtask

    initial begin
        bus.data_raddr = '0;
        bus.data_re    = 1'b0;
        bus.data_waddr = '0;
        bus.data_wdata = '0;
        bus.data_wstrb = '0;
        bus.data_we    = 1'b0;
        bus.ram_rdata  = '0;
        test_reset();
        test_ram_path();
        test_led_strobes();
        test_timer_wrap();
        test_timer_irq();
        test_switch_sync();
        test_same_cycle();
        test_unmapped();
        test_prescale();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
